chan_cksum_regs: RTL and testbench

Parametrised channel-attached checksum engine and register bank. It sits on the comm_fpga channel interface, alongside comm_fpga_epp/comm_fpga_fx2, in one clock domain.
- Accumulates a W-bit checksum (simple sum or Fletcher) over bytes written to a data channel.
- Provides a snapshot-and-stream readback of the checksum, byte-serial with flow control.
- Exposes NUM_REGS general 8-bit read/write channel registers at a configurable base address.

---
 rtl/chan_cksum_pkg.sv | 16 +
 rtl/cksum_accum.sv | 62 ++++++
 rtl/chan_cksum_regs.sv | 138 +++++++++++++
 tb/tb_chan_cksum_regs.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/chan_cksum_pkg.sv
// Shared channel map and register bit positions for the channel checksum block.
package chan_cksum_pkg;

    localparam logic [6:0] OFF_DATA  = 7'd0;
    localparam logic [6:0] OFF_CTRL  = 7'd1;
    localparam logic [6:0] OFF_CKSUM = 7'd2;
    localparam logic [6:0] OFF_REG0  = 7'd3;

    localparam int unsigned CTRL_CLEAR = 0;
    localparam int unsigned CTRL_SNAP  = 1;

    localparam int unsigned STAT_SNAP    = 7;
    localparam int unsigned STAT_MODE    = 6;
    localparam int unsigned STAT_PTR_LSB = 0;

endpackage

// File: rtl/cksum_accum.sv
// Checksum accumulator: additive sum mod 2^W or Fletcher-W with end-around-carry folding.
module cksum_accum #(
    parameter int unsigned W        = 16,
    parameter bit          FLETCHER = 1'b0
) (
    input  logic         clk_in,
    input  logic         reset_in,
    input  logic         clear,
    input  logic         en,
    input  logic [7:0]   data,
    output logic [W-1:0] sum
);

    if (FLETCHER) begin : g_fletcher
        localparam int unsigned H = W / 2;
        localparam logic [H-1:0] M = '1;

        logic [H-1:0] a;
        logic [H-1:0] b;
        logic [H-1:0] a_next;
        logic [H-1:0] b_next;

        // Operands stay below M, so a single carry fold is enough; all-ones is the alias of zero.
        function automatic logic [H-1:0] add_mod(input logic [H-1:0] x, input logic [H-1:0] y);
            logic [H:0]   s;
            logic [H-1:0] t;
            s = {1'b0, x} + {1'b0, y};
            t = s[H-1:0] + {{(H-1){1'b0}}, s[H]};
            return (t == M) ? '0 : t;
        endfunction

        always_comb begin
            a_next = add_mod(a, H'(data));
            b_next = add_mod(b, a_next);
        end

        always_ff @(posedge clk_in) begin
            if (reset_in || clear) begin
                a <= '0;
                b <= '0;
            end else if (en) begin
                a <= a_next;
                b <= b_next;
            end
        end

        assign sum = {b, a};
    end else begin : g_simple
        logic [W-1:0] acc;

        always_ff @(posedge clk_in) begin
            if (reset_in || clear) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc + W'(data);
            end
        end

        assign sum = acc;
    end

endmodule

// File: rtl/chan_cksum_regs.sv
// Channel-attached checksum engine with snapshot readback and general-purpose registers.
module chan_cksum_regs
    import chan_cksum_pkg::*;
#(
    parameter int unsigned CKSUM_WIDTH = 16,
    parameter int unsigned NUM_REGS    = 4,
    parameter logic [6:0]  BASE_ADDR   = 7'h00,
    parameter bit          FLETCHER    = 1'b0
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [6:0]              chanAddr_in,
    input  logic [7:0]              h2fData_in,
    input  logic                    h2fValid_in,
    output logic                    h2fReady_out,
    output logic [7:0]              f2hData_out,
    output logic                    f2hValid_out,
    input  logic                    f2hReady_in,
    output logic [CKSUM_WIDTH-1:0]  cksum_out,
    output logic [15:0]             count_out,
    output logic [8*NUM_REGS-1:0]   regs_out,
    output logic                    snapValid_out
);

    localparam int unsigned NB       = CKSUM_WIDTH / 8;
    localparam logic [3:0]  LAST_PTR = 4'(NB - 1);

    logic [6:0]             off;
    logic                   hit;
    logic                   wr;
    logic                   data_wr;
    logic                   ctrl_wr;
    logic                   clear;
    logic                   snap_take;
    logic                   consume;
    logic [CKSUM_WIDTH-1:0] snap;
    logic [3:0]             ptr;
    logic                   snap_valid;
    logic [7:0]             last_byte;
    logic [15:0]            count;
    logic [7:0]             regs [NUM_REGS];
    logic [7:0]             status;
    logic [7:0]             snap_byte;

    assign off          = chanAddr_in - BASE_ADDR;
    assign hit          = (chanAddr_in >= BASE_ADDR) && (off < 7'(OFF_REG0 + 7'(NUM_REGS)));
    assign h2fReady_out = !reset_in;
    assign wr           = h2fValid_in && h2fReady_out && hit;
    assign data_wr      = wr && (off == OFF_DATA);
    assign ctrl_wr      = wr && (off == OFF_CTRL);
    assign clear        = ctrl_wr && h2fData_in[CTRL_CLEAR];
    assign snap_take    = ctrl_wr && h2fData_in[CTRL_SNAP];
    assign consume      = hit && (off == OFF_CKSUM) && snap_valid && f2hReady_in;

    cksum_accum #(
        .W        (CKSUM_WIDTH),
        .FLETCHER (FLETCHER)
    ) u_accum (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clear    (clear),
        .en       (data_wr),
        .data     (h2fData_in),
        .sum      (cksum_out)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            last_byte  <= '0;
            count      <= '0;
            snap       <= '0;
            ptr        <= '0;
            snap_valid <= 1'b0;
            for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            if (data_wr) begin
                last_byte <= h2fData_in;
                if (count != '1) count <= count + 16'd1;
            end
            if (clear) count <= '0;
            // cksum_out still holds the pre-clear value here, so a combined clear+snap captures it.
            if (snap_take) begin
                snap       <= cksum_out;
                ptr        <= '0;
                snap_valid <= 1'b1;
            end else if (consume) begin
                if (ptr == LAST_PTR) begin
                    ptr        <= '0;
                    snap_valid <= 1'b0;
                end else begin
                    ptr <= ptr + 4'd1;
                end
            end
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr && (off == OFF_REG0 + 7'(k))) regs[k] <= h2fData_in;
            end
        end
    end

    always_comb begin
        regs_out = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) regs_out[8*k +: 8] = regs[k];
    end

    always_comb begin
        status                       = '0;
        status[STAT_SNAP]            = snap_valid;
        status[STAT_MODE]            = FLETCHER;
        status[STAT_PTR_LSB +: 4]    = ptr;
        snap_byte                    = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            if (ptr == 4'(k)) snap_byte = snap[8*k +: 8];
        end
    end

    always_comb begin
        f2hData_out  = 8'h00;
        f2hValid_out = 1'b1;
        if (hit) begin
            if (off == OFF_DATA) begin
                f2hData_out = last_byte;
            end else if (off == OFF_CTRL) begin
                f2hData_out = status;
            end else if (off == OFF_CKSUM) begin
                f2hData_out  = snap_byte;
                f2hValid_out = snap_valid;
            end else begin
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    if (off == OFF_REG0 + 7'(k)) f2hData_out = regs[k];
                end
            end
        end
    end

    assign count_out     = count;
    assign snapValid_out = snap_valid;

endmodule

// File: tb/tb_chan_cksum_regs.sv
// Directed bench: four differently configured instances share one host channel bus.
module tb_chan_cksum_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] addr;
    logic [7:0] din;
    logic       valid;
    logic       rdy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // s16: W=16 simple, f16: W=16 Fletcher, s32: W=32 simple, r16: base 0x20 with 2 regs
    logic        s16_hrdy, f16_hrdy, s32_hrdy, r16_hrdy;
    logic [7:0]  s16_fd, f16_fd, s32_fd, r16_fd;
    logic        s16_fv, f16_fv, s32_fv, r16_fv;
    logic [15:0] s16_ck, f16_ck, r16_ck;
    logic [31:0] s32_ck;
    logic [15:0] s16_cnt, f16_cnt, s32_cnt, r16_cnt;
    logic [31:0] s16_regs, f16_regs, s32_regs;
    logic [15:0] r16_regs;
    logic        s16_sv, f16_sv, s32_sv, r16_sv;

    always #5 clk = ~clk;

    chan_cksum_regs #(.CKSUM_WIDTH(16), .NUM_REGS(4), .BASE_ADDR(7'h00), .FLETCHER(1'b0)) u_s16 (
        .clk_in(clk), .reset_in(rst), .chanAddr_in(addr), .h2fData_in(din), .h2fValid_in(valid),
        .h2fReady_out(s16_hrdy), .f2hData_out(s16_fd), .f2hValid_out(s16_fv), .f2hReady_in(rdy),
        .cksum_out(s16_ck), .count_out(s16_cnt), .regs_out(s16_regs), .snapValid_out(s16_sv));

    chan_cksum_regs #(.CKSUM_WIDTH(16), .NUM_REGS(4), .BASE_ADDR(7'h00), .FLETCHER(1'b1)) u_f16 (
        .clk_in(clk), .reset_in(rst), .chanAddr_in(addr), .h2fData_in(din), .h2fValid_in(valid),
        .h2fReady_out(f16_hrdy), .f2hData_out(f16_fd), .f2hValid_out(f16_fv), .f2hReady_in(rdy),
        .cksum_out(f16_ck), .count_out(f16_cnt), .regs_out(f16_regs), .snapValid_out(f16_sv));

    chan_cksum_regs #(.CKSUM_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(7'h00), .FLETCHER(1'b0)) u_s32 (
        .clk_in(clk), .reset_in(rst), .chanAddr_in(addr), .h2fData_in(din), .h2fValid_in(valid),
        .h2fReady_out(s32_hrdy), .f2hData_out(s32_fd), .f2hValid_out(s32_fv), .f2hReady_in(rdy),
        .cksum_out(s32_ck), .count_out(s32_cnt), .regs_out(s32_regs), .snapValid_out(s32_sv));

    chan_cksum_regs #(.CKSUM_WIDTH(16), .NUM_REGS(2), .BASE_ADDR(7'h20), .FLETCHER(1'b0)) u_r16 (
        .clk_in(clk), .reset_in(rst), .chanAddr_in(addr), .h2fData_in(din), .h2fValid_in(valid),
        .h2fReady_out(r16_hrdy), .f2hData_out(r16_fd), .f2hValid_out(r16_fv), .f2hReady_in(rdy),
        .cksum_out(r16_ck), .count_out(r16_cnt), .regs_out(r16_regs), .snapValid_out(r16_sv));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        addr  = a;
        din   = d;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic burst(input logic [6:0] a, input logic [7:0] d, input int unsigned n);
        addr  = a;
        din   = d;
        valid = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic take();
        rdy = 1'b1;
        @(posedge clk);
        #1;
        rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = '0; din = 8'h55; valid = 1'b1; rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ready_in_reset", 64'(s16_hrdy), 64'h0);
        rst = 1'b0; valid = 1'b0;
        #1;
        chk("ready_after_reset", 64'(s16_hrdy), 64'h1);
        chk("reset_cksum", 64'(s16_ck), 64'h0);
        chk("reset_count", 64'(s16_cnt), 64'h0);
        chk("reset_snapvalid", 64'(s32_sv), 64'h0);
        chk("reset_regs", 64'(s16_regs), 64'h0);
        addr = 7'd0; #1;
        chk("reset_lastbyte", 64'({s16_fv, s16_fd}), 64'h100);

        // simple W=16
        wr(7'd0, 8'h01); wr(7'd0, 8'hFF); wr(7'd0, 8'h10);
        chk("simple_cksum", 64'(s16_ck), 64'h0110);
        chk("simple_count", 64'(s16_cnt), 64'd3);
        addr = 7'd0; #1;
        chk("read_data", 64'({s16_fv, s16_fd}), 64'h110);
        addr = 7'd1; #1;
        chk("status_simple", 64'({s16_fv, s16_fd}), 64'h100);
        chk("status_fletcher", 64'({f16_fv, f16_fd}), 64'h140);

        // Fletcher W=16
        do_reset();
        wr(7'd0, 8'h01); wr(7'd0, 8'h02);
        chk("fletcher_ab", 64'(f16_ck), 64'h0403);
        wr(7'd0, 8'hFC);
        chk("fletcher_norm", 64'(f16_ck), 64'h0400);
        chk("simple_same_bytes", 64'(s16_ck), 64'h00FF);

        // W=32 stream of 0x123456
        do_reset();
        burst(7'd0, 8'hFF, 4678);
        wr(7'd0, 8'h9C);
        chk("s32_cksum", 64'(s32_ck), 64'h0012_3456);
        addr = 7'd2; #1;
        chk("cksum_empty_stall", 64'(s32_fv), 64'h0);
        wr(7'd1, 8'h02);
        chk("s32_snapvalid", 64'(s32_sv), 64'h1);
        addr = 7'd2; #1;
        chk("s32_byte0", 64'({s32_fv, s32_fd}), 64'h156);
        take();
        chk("s32_byte1", 64'({s32_fv, s32_fd}), 64'h134);
        take();
        addr = 7'd1; #1;
        chk("s32_status_mid", 64'(s32_fd), 64'h82);
        addr = 7'd2; #1;
        chk("s32_byte2", 64'({s32_fv, s32_fd}), 64'h112);
        take();
        chk("s32_byte3", 64'({s32_fv, s32_fd}), 64'h100);
        chk("s32_sv_before_last", 64'(s32_sv), 64'h1);
        take();
        chk("s32_sv_after_last", 64'(s32_sv), 64'h0);
        chk("s32_fifth_stall", 64'(s32_fv), 64'h0);

        // combined clear + snapshot
        do_reset();
        wr(7'd0, 8'h01); wr(7'd0, 8'hFF); wr(7'd0, 8'h10);
        wr(7'd1, 8'h03);
        chk("clrsnap_cksum", 64'(s16_ck), 64'h0);
        chk("clrsnap_count", 64'(s16_cnt), 64'h0);
        chk("clrsnap_sv", 64'(s16_sv), 64'h1);
        addr = 7'd2; #1;
        chk("clrsnap_byte0", 64'({s16_fv, s16_fd}), 64'h110);
        take();
        chk("clrsnap_byte1", 64'({s16_fv, s16_fd}), 64'h101);
        take();
        chk("clrsnap_done", 64'(s16_sv), 64'h0);

        // register bank and address decode
        do_reset();
        wr(7'h23, 8'hA5); wr(7'h24, 8'h5A);
        chk("r16_regs", 64'(r16_regs), 64'h5AA5);
        wr(7'h25, 8'hFF);
        chk("r16_regs_oob", 64'(r16_regs), 64'h5AA5);
        addr = 7'h25; #1;
        chk("r16_read_oob", 64'({r16_fv, r16_fd}), 64'h100);
        addr = 7'h24; #1;
        chk("r16_read_reg1", 64'({r16_fv, r16_fd}), 64'h15A);
        chk("s16_regs_untouched", 64'(s16_regs), 64'h0);
        wr(7'd3, 8'h77); wr(7'd6, 8'hC3);
        chk("s16_regs", 64'(s16_regs), 64'hC300_0077);
        chk("r16_cksum_untouched", 64'(r16_ck), 64'h0);
        addr = 7'd6; #1;
        chk("s16_read_reg3", 64'({s16_fv, s16_fd}), 64'h1C3);

        // reset during readback
        do_reset();
        wr(7'd0, 8'h01); wr(7'd0, 8'hFF); wr(7'd0, 8'h10);
        wr(7'd1, 8'h02);
        addr = 7'd2;
        take();
        chk("mid_byte1", 64'({s16_fv, s16_fd}), 64'h101);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_sv", 64'(s16_sv), 64'h0);
        chk("mid_rst_cksum", 64'(s16_ck), 64'h0);
        chk("mid_rst_ready", 64'(s16_hrdy), 64'h0);
        rst = 1'b0;
        addr = 7'd1; #1;
        chk("mid_rst_status", 64'(s16_fd), 64'h00);

        // modulo wrap
        do_reset();
        burst(7'd0, 8'hFF, 257);
        chk("wrap_full", 64'(s16_ck), 64'hFFFF);
        wr(7'd0, 8'h02);
        chk("wrap_over", 64'(s16_ck), 64'h0001);
        chk("wrap_count", 64'(s16_cnt), 64'h0102);

        // count saturation and clear
        do_reset();
        burst(7'd0, 8'h00, 65535);
        chk("count_max", 64'(s16_cnt), 64'hFFFF);
        burst(7'd0, 8'h00, 2);
        chk("count_sat", 64'(s16_cnt), 64'hFFFF);
        wr(7'd1, 8'h01);
        chk("count_clear", 64'(s16_cnt), 64'h0);
        chk("clear_no_snap", 64'(s16_sv), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
